// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spi_controller
//  Purpose  : SPI mode-0 write initiator. Takes one {rw, addr, data} request
//             over valid/ready and sends it as a 16-bit MSB-first frame on
//             nCS/SCLK/COPI. The frame timing leaves enough margin for a
//             receiver that samples these lines through 2-FF synchronizers.
//  Ports    : clk, rst_n             - clock, async active-low reset
//             req_valid / req_ready  - request handshake (ready only in IDLE)
//             req_rw/addr/data       - frame bits 15 / 14:8 / 7:0
//             busy                   - frame or gap in progress
//             done                   - one-cycle pulse as nCS returns high
//             nCS, SCLK, COPI        - SPI lines (all registered)
//  Revision : 1.0 - initial release
// ============================================================================
module spi_controller #(
    parameter int CLK_DIV = 4,  // clk cycles per SCLK half-period, >= 3
    parameter int GAP_CYC = 8   // minimum nCS-high cycles between frames, >= 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [4:0]       LAST_BIT  = 5'd16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_TRAIL = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]       state_q,    state_d;
    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic [4:0]       bit_cnt_q,  bit_cnt_d;
    // Bit 15 of the frame goes straight onto COPI at accept, so only the
    // remaining 15 bits need to be held for shifting.
    logic [14:0]      shreg_q,    shreg_d;
    logic             ncs_q,      ncs_d;
    logic             sclk_q,     sclk_d;
    logic             copi_q,     copi_d;
    logic             ready_q,    ready_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ncs_d      = ncs_q;
        sclk_d     = sclk_q;
        copi_d     = copi_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d    = S_LEAD;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shreg_d    = {req_addr, req_data};
                    ncs_d      = 1'b0;
                    copi_d     = req_rw;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            // nCS low, SCLK low for one half-period before the first rise.
            S_LEAD: begin
                if (half_cnt_q == HALF_LAST) begin
                    state_d    = S_SHIFT;
                    half_cnt_d = '0;
                    sclk_d     = 1'b1;
                    bit_cnt_d  = bit_cnt_q + 5'd1;
                end else begin
                    half_cnt_d = half_cnt_q + CNT_W'(1);
                end
            end

            // SCLK toggles every half-period. COPI only moves on a falling
            // edge, so it is stable across every rising edge. The low phase
            // after the 16th fall completes the last period before TRAIL.
            S_SHIFT: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q != LAST_BIT) begin
                            copi_d  = shreg_q[14];
                            shreg_d = {shreg_q[13:0], 1'b0};
                        end
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_TRAIL;
                    end else begin
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + CNT_W'(1);
                end
            end

            S_TRAIL: begin
                if (half_cnt_q == HALF_LAST) begin
                    state_d    = S_GAP;
                    half_cnt_d = '0;
                    gap_cnt_d  = '0;
                    ncs_d      = 1'b1;
                    done_d     = 1'b1;
                    copi_d     = 1'b0;
                end else begin
                    half_cnt_d = half_cnt_q + CNT_W'(1);
                end
            end

            // The done cycle is the first of the GAP_CYC nCS-high cycles.
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                ncs_d   = 1'b1;
                sclk_d  = 1'b0;
                copi_d  = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            half_cnt_q <= '0;
            gap_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ncs_q      <= 1'b1;
            sclk_q     <= 1'b0;
            copi_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ncs_q      <= ncs_d;
            sclk_q     <= sclk_d;
            copi_q     <= copi_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign nCS       = ncs_q;
    assign SCLK      = sclk_q;
    assign COPI      = copi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_controller
//  Purpose  : Self-checking bench for spi_controller. A line monitor decodes
//             every frame (bits captured at SCLK rise, edge count, nCS low
//             and high durations, done alignment) and tests compare those
//             against values derived from the frame format and timing rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_controller;

    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 8;
    localparam int LOW_CYC = 34 * CLK_DIV;
    localparam int ACC2RDY = 34 * CLK_DIV + GAP_CYC + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready, busy, done, nCS, SCLK, COPI;

    spi_controller #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .done      (done),
        .nCS       (nCS),
        .SCLK      (SCLK),
        .COPI      (COPI)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          edges;
        int          low;
        int          gap;
        bit          done_at_rise;
    } frame_t;

    typedef struct {
        bit          rw;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp;
    } vec_t;

    frame_t obs_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int stray_sclk = 0;
    int cur_edges = 0;
    int frames_exp = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line monitor, sampled on the falling clk edge.
    initial begin : mon
        logic        prev_ncs;
        logic        prev_sclk;
        logic [15:0] bits;
        int          low;
        int          hi;
        int          gap;
        bit          inf;
        prev_ncs = 1'b1; prev_sclk = 1'b0; bits = '0;
        low = 0; hi = 0; gap = 0; inf = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ncs = 1'b1; prev_sclk = 1'b0; inf = 1'b0;
                cur_edges = 0; hi = 0;
            end else begin
                if (done) done_cnt++;
                if (prev_ncs && !nCS) begin
                    inf = 1'b1; bits = '0; low = 0; cur_edges = 0; gap = hi;
                end
                if (!nCS) begin
                    low++;
                    if (!prev_sclk && SCLK) begin
                        bits = {bits[14:0], COPI};
                        cur_edges++;
                    end
                end else if (SCLK) begin
                    stray_sclk++;
                end
                if (!prev_ncs && nCS && inf) begin
                    obs_q.push_back('{bits, cur_edges, low, gap, done});
                    inf = 1'b0;
                    hi = 0;
                end
                if (nCS) hi++;
                prev_ncs = nCS;
                prev_sclk = SCLK;
            end
        end
    end

    // Called just after a falling edge; returns with req_ready high or ok=0.
    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        while (req_ready !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic check_frame(input string tag, input frame_t f, input logic [15:0] exp);
        chk({tag, "_bits"}, f.bits, exp);
        chk({tag, "_edges"}, f.edges, 16);
        chk({tag, "_ncs_low"}, f.low, LOW_CYC);
        chk({tag, "_done_at_rise"}, f.done_at_rise, 1);
    endtask

    // One request; optionally scribble on valid/fields while the frame runs.
    task automatic do_one(input string tag, input bit rw, input logic [6:0] addr,
                          input logic [7:0] data, input logic [15:0] exp, input bit disturb);
        bit     ok;
        int     n;
        frame_t f;
        @(negedge clk);
        req_rw = rw; req_addr = addr; req_data = data; req_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            chk({tag, "_accept_timeout"}, 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        frames_exp++;
        chk({tag, "_acc_ncs"}, nCS, 0);
        chk({tag, "_acc_copi"}, COPI, rw);
        chk({tag, "_acc_ready"}, req_ready, 0);
        chk({tag, "_acc_busy"}, busy, 1);
        n = 1;
        while (req_ready !== 1'b1 && n < 2000) begin
            if (disturb) begin
                req_valid = 1'($urandom_range(0, 1));
                req_rw    = 1'($urandom);
                req_addr  = 7'($urandom);
                req_data  = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        chk({tag, "_accept_to_ready"}, n, ACC2RDY);
        if (obs_q.size() == 0) begin
            chk({tag, "_frame_missing"}, 0, 1);
        end else begin
            f = obs_q.pop_front();
            check_frame(tag, f, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t   vecs[7];
        vec_t   bb[3];
        frame_t f;
        bit     ok;
        int     n;
        int     lows;
        int     d0;
        bit          r_rw;
        logic [6:0]  r_addr;
        logic [7:0]  r_data;
        int          r_exp;

        vecs[0] = '{1'b1, 7'h04, 8'h80, 16'h8480};
        vecs[1] = '{1'b0, 7'h01, 8'hFF, 16'h01FF};
        vecs[2] = '{1'b1, 7'h7F, 8'h00, 16'hFF00};
        vecs[3] = '{1'b1, 7'h00, 8'hA5, 16'h80A5};
        vecs[4] = '{1'b1, 7'h03, 8'h3C, 16'h833C};
        vecs[5] = '{1'b0, 7'h00, 8'h00, 16'h0000};
        vecs[6] = '{1'b1, 7'h55, 8'hAA, 16'hD5AA};
        bb[0]   = '{1'b1, 7'h11, 8'h22, 16'h9122};
        bb[1]   = '{1'b0, 7'h6A, 8'h5B, 16'h6A5B};
        bb[2]   = '{1'b1, 7'h2C, 8'hF0, 16'hACF0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ncs", nCS, 1);
        chk("rst_sclk", SCLK, 0);
        chk("rst_copi", COPI, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 7; i++)
            do_one($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].data,
                   vecs[i].exp, 1'b0);

        // Back-to-back: valid held high across three requests
        @(negedge clk);
        req_rw = bb[0].rw; req_addr = bb[0].addr; req_data = bb[0].data; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready(ok);
            if (!ok) begin
                chk("b2b_accept_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            @(negedge clk);
            frames_exp++;
            if (i < 2) begin
                req_rw = bb[i+1].rw; req_addr = bb[i+1].addr; req_data = bb[i+1].data;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n = 0;
        while (obs_q.size() < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_frame_count", obs_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (obs_q.size() == 0) break;
            f = obs_q.pop_front();
            check_frame($sformatf("b2b%0d", i), f, bb[i].exp);
            if (i > 0) chk($sformatf("b2b%0d_gap", i), f.gap, GAP_CYC + 1);
        end
        wait_ready(ok);
        chk("b2b_ready_back", ok, 1);

        // Fields and valid toggled mid-frame; no extra accept afterwards
        do_one("disturb", 1'b1, 7'h2A, 8'h69, 16'hAA69, 1'b1);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!nCS) lows++;
        end
        chk("disturb_no_extra_accept", lows, 0);
        chk("disturb_no_extra_frame", obs_q.size(), 0);

        // Reset during bit 9 of the shift phase
        @(negedge clk);
        req_rw = 1'b1; req_addr = 7'h12; req_data = 8'h34; req_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (cur_edges < 9 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach_bit9", cur_edges, 9);
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ncs", nCS, 1);
        chk("rst_mid_sclk", SCLK, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_done", done_cnt, d0);
        chk("rst_mid_no_frame", obs_q.size(), 0);
        do_one("after_rst", 1'b1, 7'h12, 8'h34, 16'h9234, 1'b0);

        // Randomized requests against the frame-format model
        for (int i = 0; i < 12; i++) begin
            r_rw   = 1'($urandom);
            r_addr = 7'($urandom);
            r_data = 8'($urandom);
            r_exp  = int'(r_rw) * 32768 + int'(r_addr) * 256 + int'(r_data);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_one($sformatf("rnd%0d", i), r_rw, r_addr, r_data, 16'(r_exp),
                   ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("total_done_pulses", done_cnt, frames_exp);
        chk("sclk_outside_frame", stray_sclk, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
